// File: rtl/ma_lsu_rv32.sv
// Single-outstanding RV32 load/store unit: byte-lane steering, misalignment
// trap, sign/zero extension and a bounded wait for the memory acknowledge.
module ma_lsu_rv32 #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iValid,
  output logic              oReady,
  input  logic [4:0]        iDecodedOP,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [31:0]       iStoreData,
  input  logic [4:0]        iDregADDR,
  input  logic [31:0]       iDregDATA,
  output logic              oMemReq,
  output logic              oMemWE,
  output logic [3:0]        oMemBE,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [31:0]       oMemWData,
  input  logic              iMemAck,
  input  logic [31:0]       iMemRData,
  output logic              oValid,
  output logic [4:0]        oDregADDR,
  output logic [31:0]       oDregDATA,
  output logic              oMisalign,
  output logic              oBusErr
);

  // Memory opcodes as emitted by the decoder; every other code is an ALU op.
  localparam logic [4:0] OP_LB  = 5'h10;
  localparam logic [4:0] OP_LH  = 5'h11;
  localparam logic [4:0] OP_LW  = 5'h12;
  localparam logic [4:0] OP_LBU = 5'h13;
  localparam logic [4:0] OP_LHU = 5'h14;
  localparam logic [4:0] OP_SB  = 5'h18;
  localparam logic [4:0] OP_SH  = 5'h19;
  localparam logic [4:0] OP_SW  = 5'h1A;

  // Counter holds 0..TIMEOUT-1; the terminal value is detected, not stored.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  typedef struct packed {
    logic  mem;
    logic  store;
    logic  uns;
    size_t size;
  } dec_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               valid_q, valid_d;
  logic               mis_q, mis_d;
  logic               berr_q, berr_d;
  logic [4:0]         wb_addr_q, wb_addr_d;
  logic [31:0]        wb_data_q, wb_data_d;

  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [3:0]         be_q, be_d;
  logic [ADDR_W-1:0]  maddr_q, maddr_d;
  logic [31:0]        wdata_q, wdata_d;

  size_t              size_q, size_d;
  logic               uns_q, uns_d;
  logic               store_q, store_d;
  logic [1:0]         off_q, off_d;
  logic [4:0]         rd_q, rd_d;

  dec_t               dec;
  logic               accept;
  logic               misaligned;
  logic               timeout_hit;
  logic [3:0]         be_new;
  logic [31:0]        wdata_new;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic [31:0]        load_data;

  assign oReady = (state_q == S_IDLE);
  assign accept = iValid & oReady;

  always_comb begin
    dec = '{mem: 1'b1, store: 1'b0, uns: 1'b0, size: SZ_W};
    case (iDecodedOP)
      OP_LB:   dec.size = SZ_B;
      OP_LH:   dec.size = SZ_H;
      OP_LW:   dec.size = SZ_W;
      OP_LBU:  begin dec.size = SZ_B; dec.uns = 1'b1; end
      OP_LHU:  begin dec.size = SZ_H; dec.uns = 1'b1; end
      OP_SB:   begin dec.size = SZ_B; dec.store = 1'b1; end
      OP_SH:   begin dec.size = SZ_H; dec.store = 1'b1; end
      OP_SW:   begin dec.size = SZ_W; dec.store = 1'b1; end
      default: dec.mem = 1'b0;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = 32'h0;
    case (dec.size)
      SZ_B: begin
        be_new = 4'b0001 << iAddr[1:0];
        if (dec.store) wdata_new = {4{iStoreData[7:0]}};
      end
      SZ_H: begin
        misaligned = iAddr[0];
        be_new     = 4'b0011 << iAddr[1:0];
        if (dec.store) wdata_new = {2{iStoreData[15:0]}};
      end
      default: begin
        misaligned = (iAddr[1:0] != 2'b00);
        if (dec.store) wdata_new = iStoreData;
      end
    endcase
  end

  // Lane extraction uses the offset latched at accept, not the live address.
  assign lane_b = iMemRData[{off_q, 3'b000} +: 8];
  assign lane_h = iMemRData[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      SZ_B:    load_data = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_H:    load_data = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_data = iMemRData;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    wb_addr_d = 5'd0;
    wb_data_d = 32'h0;
    req_d     = req_q;
    we_d      = we_q;
    be_d      = be_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    store_d   = store_q;
    off_d     = off_q;
    rd_d      = rd_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!dec.mem) begin
            valid_d   = 1'b1;
            wb_addr_d = iDregADDR;
            wb_data_d = iDregDATA;
          end else if (misaligned) begin
            valid_d = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = dec.store;
            be_d    = be_new;
            maddr_d = {iAddr[ADDR_W-1:2], 2'b00};
            wdata_d = wdata_new;
            size_d  = dec.size;
            uns_d   = dec.uns;
            store_d = dec.store;
            off_d   = iAddr[1:0];
            rd_d    = iDregADDR;
          end
        end
      end
      default: begin
        if (iMemAck || timeout_hit) begin
          state_d = S_IDLE;
          valid_d = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          maddr_d = '0;
          wdata_d = 32'h0;
          if (!iMemAck) begin
            berr_d = 1'b1;
          end else if (!store_q) begin
            wb_addr_d = rd_q;
            wb_data_d = load_data;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'h0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      maddr_q   <= '0;
      wdata_q   <= 32'h0;
      size_q    <= SZ_W;
      uns_q     <= 1'b0;
      store_q   <= 1'b0;
      off_q     <= 2'b00;
      rd_q      <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      req_q     <= req_d;
      we_q      <= we_d;
      be_q      <= be_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      store_q   <= store_d;
      off_q     <= off_d;
      rd_q      <= rd_d;
    end
  end

  assign oValid    = valid_q;
  assign oMisalign = mis_q;
  assign oBusErr   = berr_q;
  assign oDregADDR = wb_addr_q;
  assign oDregDATA = wb_data_q;
  assign oMemReq   = req_q;
  assign oMemWE    = we_q;
  assign oMemBE    = be_q;
  assign oMemAddr  = maddr_q;
  assign oMemWData = wdata_q;

endmodule

// File: doc/ma_lsu_rv32.md
MA_LSU_RV32 -- requirements
Module: ma_lsu_rv32

Interface
REQ-001 Parameter ADDR_W, default 32, data-memory address width in bits (>= 2).
REQ-002 Parameter TIMEOUT, default 16, cycles to wait for iMemAck before bus error; 0 disables timeout.
REQ-003 One clock; reset is asynchronous and active-high; ports are iCLK and iRST.
REQ-004 iCLK  in  1  clock.
REQ-005 iRST  in  1  asynchronous active-high reset.
REQ-006 iValid  in  1  upstream stage presents an operation.
REQ-007 oReady  out  1  block accepts the operation this cycle.
REQ-008 iDecodedOP  in  5  operation code from DecodedOP.vh.
REQ-009 iAddr  in  ADDR_W  effective memory address.
REQ-010 iStoreData  in  32  rs2 data for stores.
REQ-011 iDregADDR  in  5  destination register address.
REQ-012 iDregDATA  in  32  ALU result for non-memory operations.
REQ-013 oMemReq  out  1  memory request valid.
REQ-014 oMemWE  out  1  1 = write, 0 = read.
REQ-015 oMemBE  out  4  byte enables.
REQ-016 oMemAddr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
REQ-017 oMemWData  out  32  lane-replicated store data.
REQ-018 iMemAck  in  1  memory completes the request; iMemRData valid.
REQ-019 iMemRData  in  32  read word.
REQ-020 oValid  out  1  one-cycle writeback pulse.
REQ-021 oDregADDR  out  5  writeback register; 0 = no writeback.
REQ-022 oDregDATA  out  32  writeback data.
REQ-023 oMisalign  out  1  qualifies oValid: misaligned access, no memory request issued.
REQ-024 oBusErr  out  1  qualifies oValid: timeout, request abandoned.

Function
REQ-025 FSM states IDLE and WAIT; oReady = 1 only in IDLE.
REQ-026 Accept = iValid & oReady; all inputs sampled on that edge only.
REQ-027 Non-memory op accepted: next cycle oValid=1, oDregADDR=iDregADDR, oDregDATA=iDregDATA; state stays IDLE (1-cycle latency).
REQ-028 Memory ops: LB, LH, LW, LBU, LHU, SB, SH, SW; offset = iAddr[1:0].
REQ-029 Misaligned: LH/LHU/SH with offset[0]=1, or LW/SW with offset!=0; next cycle oValid=1, oMisalign=1, oDregADDR=0, oDregDATA=0, no oMemReq, state IDLE.
REQ-030 Aligned memory op: next cycle oMemReq=1 with oMemAddr={iAddr[ADDR_W-1:2],2'b00}, oMemWE=1 for stores; state WAIT.
REQ-031 BE: byte ops 4'b0001<<offset; half ops 4'b0011<<offset; word ops 4'b1111; loads drive same BE.
REQ-032 oMemWData: SB {4{byte}}, SH {2{half}}, SW word; loads drive 0.
REQ-033 oMemReq, oMemWE, oMemBE, oMemAddr, oMemWData held stable throughout WAIT until the ack cycle.
REQ-034 In WAIT with iMemAck=1: oMemReq drops next cycle; oValid=1 next cycle; state IDLE.
REQ-035 Load result: lane = iMemRData byte/half at offset; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; oDregADDR = latched rd.
REQ-036 Store completion: oDregADDR=0, oDregDATA=0.
REQ-037 Wait counter cleared on entry to WAIT, increments each WAIT cycle without ack; at TIMEOUT (>0) and no ack: oMemReq drops, oValid=1, oBusErr=1, oDregADDR=0, state IDLE.
REQ-038 Ack in the timeout cycle: ack wins, normal completion, oBusErr=0.
REQ-039 iMemAck in IDLE ignored; no outputs change.
REQ-040 Maximum throughput: one non-memory op per cycle; memory ops at least 3 cycles accept-to-accept.
REQ-041 oValid, oMisalign, oBusErr are single-cycle pulses; oMisalign and oBusErr never both 1.

Reset
REQ-042 iRST=1 immediately forces IDLE, counter 0, all outputs 0 except oReady=1, including mid-WAIT (request abandoned, no oValid).
REQ-043 First accept possible on the first rising edge after iRST deasserts.

Verification
REQ-044 LB addr 0x1003, iMemRData 0x80FF_FF7F, ack after 2 WAIT cycles -> oMemBE=1000, oDregDATA=0xFFFF_FF80, rd written.
REQ-045 SH addr 0x2002, rs2 0x1234_ABCD -> oMemWE=1, oMemBE=1100, oMemWData=0xABCD_ABCD, completion oDregADDR=0.
REQ-046 LW addr 0x0006 -> no oMemReq, next cycle oValid=1, oMisalign=1, oDregADDR=0.
REQ-047 TIMEOUT=4, LHU with no ack -> oBusErr pulse after 4 WAIT cycles, oMemReq low afterwards; repeat with ack in cycle 4 -> normal result, oBusErr=0.
REQ-048 Back-to-back non-memory ops rd=5,6,7 -> three consecutive oValid cycles, oReady constantly 1.
REQ-049 iRST asserted during WAIT -> oMemReq=0 and oReady=1 without waiting for a clock edge, no oValid pulse.
